// File: rtl/mem_access_unit.sv
// Data-memory access unit: IDLE/BUSY/DONE handshake to a single-cycle-ack bus, with byte/half/word lanes.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse Misalign_M.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic [1:0]  SizeSrc_M,
  input  logic        LoadSign_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic        Stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        Misalign_M
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic        access;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [1:0]  size_reg;
  logic [1:0]  lane_reg;
  logic        sign_reg;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign access  = MemWrite_M | (ResultSrc_M == 2'b01);
  assign Stall_M = ((state == IDLE) && access) || (state == BUSY);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WriteData_M;
    case (SizeSrc_M)
      2'b10: begin
        be_next    = 4'b0001 << ALUResult_M[1:0];
        wdata_next = {4{WriteData_M[7:0]}};
      end
      2'b01: begin
        be_next    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{WriteData_M[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension use the size/offset captured at request time.
  always_comb begin
    lane_byte = dmem_rdata[{lane_reg, 3'b000} +: 8];
    lane_half = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_reg)
      2'b10:   load_ext = {{24{sign_reg & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{sign_reg & lane_half[15]}}, lane_half};
      default: load_ext = dmem_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((SizeSrc_M == 2'b01) && ALUResult_M[0]) ||
                      ((SizeSrc_M != 2'b01) && (SizeSrc_M != 2'b10) && (ALUResult_M[1:0] != 2'b00));
`else
  assign Misalign_M = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ReadData_M <= 32'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      size_reg   <= 2'd0;
      lane_reg   <= 2'd0;
      sign_reg   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      Misalign_M <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (misaligned) begin
              state      <= DONE;
              Misalign_M <= 1'b1;
            end else
`endif
            begin
              state      <= BUSY;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite_M;
              dmem_addr  <= {ALUResult_M[31:2], 2'b00};
              dmem_wdata <= wdata_next;
              dmem_be    <= be_next;
              size_reg   <= SizeSrc_M;
              lane_reg   <= ALUResult_M[1:0];
              sign_reg   <= LoadSign_M;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (!dmem_we) ReadData_M <= load_ext;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
          Misalign_M <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner sequences, then random traffic vs a byte-memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite_M;
  logic [1:0]  ResultSrc_M;
  logic [1:0]  SizeSrc_M;
  logic        LoadSign_M;
  logic [31:0] ALUResult_M;
  logic [31:0] WriteData_M;
  logic [31:0] ReadData_M;
  logic        Stall_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        Misalign_M;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .SizeSrc_M(SizeSrc_M), .LoadSign_M(LoadSign_M), .ALUResult_M(ALUResult_M),
    .WriteData_M(WriteData_M), .ReadData_M(ReadData_M), .Stall_M(Stall_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .Misalign_M(Misalign_M)
  );

  always #5 clk = ~clk;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] bus_mem [0:255];
  logic [31:0] ref_rd;

  typedef struct {
    bit          we;
    bit          ld;
    logic [1:0]  size;
    bit          sign;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemWrite_M  = 1'b0;
    ResultSrc_M = 2'b00;
    SizeSrc_M   = 2'b00;
    LoadSign_M  = 1'b0;
    ALUResult_M = 32'd0;
    WriteData_M = 32'd0;
  endtask

  // Entered at posedge+1 with the unit in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_op(input bit we, input bit ld, input logic [1:0] size, input bit sign,
                        input logic [31:0] addr, input logic [31:0] wd, input bit force_rd,
                        input logic [31:0] rd_val, input int waits,
                        output logic [3:0] o_be, output logic [31:0] o_wdata, output int o_stall);
    int          nbytes;
    bit          mis;
    logic [31:0] ea;
    logic [31:0] word;
    nbytes  = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
    mis     = TRAP && ((addr % nbytes) != 0);
    o_stall = 0;
    o_be    = 4'd0;
    o_wdata = 32'd0;
    MemWrite_M  = we;
    ResultSrc_M = ld ? 2'b01 : 2'b00;
    SizeSrc_M   = size;
    LoadSign_M  = sign;
    ALUResult_M = addr;
    WriteData_M = wd;
    #1;
    if (Stall_M) o_stall++;
    @(posedge clk); #1;
    if (mis) begin
      check("mis_no_req", dmem_req, 1'b0);
      check("mis_pulse", Misalign_M, 1'b1);
    end else begin
      check("bus_we", dmem_we, we);
      o_be    = dmem_be;
      o_wdata = dmem_wdata;
      for (int w = 0; w < waits; w++) begin
        check("req_wait", dmem_req, 1'b1);
        if (Stall_M) o_stall++;
        @(posedge clk); #1;
      end
      check("req_ack", dmem_req, 1'b1);
      check("bus_addr", dmem_addr, addr & ~32'd3);
      check("be_stable", dmem_be, o_be);
      if (Stall_M) o_stall++;
      dmem_ack   = 1'b1;
      dmem_rdata = force_rd ? rd_val : bus_mem[dmem_addr[9:2]];
      if (we)
        for (int b = 0; b < 4; b++)
          if (dmem_be[b]) bus_mem[dmem_addr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("req_done", dmem_req, 1'b0);
      check("mis_zero", Misalign_M, 1'b0);
    end
    // DONE cycle: a stray ack here must be ignored
    if (Stall_M) o_stall++;
    idle_inputs();
    dmem_ack   = 1'b1;
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("mis_clear", Misalign_M, 1'b0);
    ea = addr - (addr % nbytes);
    if (!mis) begin
      if (we) begin
        for (int b = 0; b < nbytes; b++) ref_mem[(ea + b) & 1023] = wd[8*b +: 8];
      end else if (!force_rd) begin
        word = 32'd0;
        for (int b = 0; b < nbytes; b++) word = word | (32'(ref_mem[(ea + b) & 1023]) << (8*b));
        if (sign && nbytes < 4 && word[8*nbytes-1]) word = word | (32'hFFFF_FFFF << (8*nbytes));
        ref_rd = word;
      end
    end
    if (!force_rd) check("rdata", ReadData_M, ref_rd);
  endtask

  vec_t        tbl [8];
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  int          o_stall;

  initial begin
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    bit          we, ld, sign, mis;
    logic [1:0]  size;
    logic [31:0] addr, wd;
    int          waits, nb;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
    for (int i = 0; i < 256; i++) bus_mem[i] = 32'd0;
    ref_rd = 32'd0;

    //         we ld size  sg addr         wd            rdata         wt be       wdata          rd            stall
    tbl[0] = '{1, 0, 2'b10, 0, 32'h1003, 32'h0000_00AB, 32'h0,        2, 4'b1000, 32'hABAB_ABAB, 32'h0,        4};
    tbl[1] = '{0, 1, 2'b10, 1, 32'h2001, 32'h0,         32'h0000_8000, 0, 4'b0010, 32'h0,        32'hFFFF_FF80, 2};
    tbl[2] = '{0, 1, 2'b01, 0, 32'h2002, 32'h0,         32'hBEEF_1234, 0, 4'b1100, 32'h0,        32'h0000_BEEF, 2};
    tbl[3] = '{1, 0, 2'b01, 0, 32'h2002, 32'h1234_ABCD, 32'h0,        1, 4'b1100, 32'hABCD_ABCD, 32'h0000_BEEF, 3};
    tbl[4] = '{0, 1, 2'b01, 1, 32'h0000, 32'h0,         32'h0000_8001, 0, 4'b0011, 32'h0,        32'hFFFF_8001, 2};
    tbl[5] = '{0, 1, 2'b10, 0, 32'h0003, 32'h0,         32'hF000_0000, 3, 4'b1000, 32'h0,        32'h0000_00F0, 5};
    tbl[6] = '{0, 1, 2'b00, 0, 32'h0100, 32'h0,         32'h1234_5678, 0, 4'b1111, 32'h0,        32'h1234_5678, 2};
    tbl[7] = '{1, 0, 2'b00, 0, 32'h0104, 32'hCAFE_F00D, 32'h0,        0, 4'b1111, 32'hCAFE_F00D, 32'h1234_5678, 2};

    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    idle_inputs();
    #12;
    check("rst_rdata", ReadData_M, 32'd0);
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be", dmem_be, 4'd0);
    check("rst_mis", Misalign_M, 1'b0);
    check("rst_stall", Stall_M, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].we, tbl[i].ld, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wd,
             1'b1, tbl[i].rdata, tbl[i].waits, o_be, o_wdata, o_stall);
      check($sformatf("vec%0d_be", i), o_be, tbl[i].exp_be);
      check($sformatf("vec%0d_wdata", i), o_wdata, tbl[i].exp_wdata);
      check($sformatf("vec%0d_rd", i), ReadData_M, tbl[i].exp_rd);
      check($sformatf("vec%0d_stall", i), o_stall, tbl[i].exp_stall);
      ref_rd = tbl[i].exp_rd;
      $display("vec %0d: addr=%h be=%b wdata=%h rd=%h stall=%0d", i, tbl[i].addr, o_be, o_wdata, ReadData_M, o_stall);
    end

    // Misaligned word load at 0x3002
`ifdef MEM_MISALIGN_TRAP_EN
    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h3002, 32'h0, 1'b1, 32'hDEAD_BEEF, 0, o_be, o_wdata, o_stall);
    check("trap_stall", o_stall, 1);
    check("trap_rd", ReadData_M, ref_rd);
`else
    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h3002, 32'h0, 1'b1, 32'hA5A5_0001, 0, o_be, o_wdata, o_stall);
    check("unal_word_rd", ReadData_M, 32'hA5A5_0001);
    check("unal_word_be", o_be, 4'b1111);
    ref_rd = 32'hA5A5_0001;
`endif
    $display("misalign word load: rd=%h stall=%0d", ReadData_M, o_stall);

    // Reset in the middle of a bus access
    MemWrite_M  = 1'b0;
    ResultSrc_M = 2'b01;
    SizeSrc_M   = 2'b00;
    ALUResult_M = 32'h0100;
    @(posedge clk); #1;
    check("pre_rst_req", dmem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_busy_req", dmem_req, 1'b0);
    check("rst_busy_rd", ReadData_M, 32'd0);
    idle_inputs();
    #1;
    check("rst_busy_stall", Stall_M, 1'b0);
    #1;
    rst = 1'b0;
    ref_rd = 32'd0;
    @(posedge clk); #1;
    check("post_rst_req", dmem_req, 1'b0);
    $display("reset during busy: req=%b rd=%h", dmem_req, ReadData_M);

    for (int n = 0; n < 80; n++) begin
      case ($urandom % 3)
        0:       begin we = 1'b1; ld = 1'b0; end
        1:       begin we = 1'b0; ld = 1'b1; end
        default: begin we = 1'b1; ld = 1'b1; end
      endcase
      size  = 2'($urandom % 4);
      sign  = 1'($urandom % 2);
      addr  = 32'($urandom % 1024);
      wd    = $urandom;
      waits = int'($urandom % 4);
      nb    = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
      mis   = TRAP && ((addr % nb) != 0);
      case (size)
        2'b10:   begin e_be = 4'b0001 << addr[1:0]; e_wd = {4{wd[7:0]}}; end
        2'b01:   begin e_be = addr[1] ? 4'b1100 : 4'b0011; e_wd = {2{wd[15:0]}}; end
        default: begin e_be = 4'b1111; e_wd = wd; end
      endcase
      run_op(we, ld, size, sign, addr, wd, 1'b0, 32'h0, waits, o_be, o_wdata, o_stall);
      if (mis) begin
        check("rnd_stall", o_stall, 1);
      end else begin
        check("rnd_stall", o_stall, waits + 2);
        check("rnd_be", o_be, e_be);
        check("rnd_wdata", o_wdata, e_wd);
      end
      $display("rnd %0d: we=%b size=%0d sign=%b addr=%h waits=%0d rd=%h", n, we, size, sign, addr, waits, ReadData_M);
      if (($urandom % 4) == 0) begin
        #1;
        check("idle_stall", Stall_M, 1'b0);
        check("idle_req", dmem_req, 1'b0);
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
